// File: rtl/debounce_tick_fsm_pkg.sv
// Shared definitions for the tick-driven debouncer: state encodings, default
// qualification length and small helpers that map a state onto its outputs.
package debounce_tick_fsm_pkg;

  localparam int STABLE_TICKS_DEF = 4;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } state_e;

  // The debounced level is high in both "settled high" and "qualifying a fall".
  function automatic logic levelOf(input state_e s);
    return (s == ST_ONE) || (s == ST_WAIT0);
  endfunction

  function automatic logic busyOf(input state_e s);
    return (s == ST_WAIT1) || (s == ST_WAIT0);
  endfunction

endpackage

// File: rtl/debounce_tick_fsm_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, cleared to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/debounce_tick_fsm.sv
// Tick-driven switch debouncer: the level only flips after the synchronised input
// has disagreed with it for STABLE_TICKS consecutive enable ticks.
module debounce_tick_fsm
  import debounce_tick_fsm_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic m_tick,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall,
  output logic busy
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          swSync;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          busy_q, busy_d;

  sync_2ff u_sync_sw (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (sw),
    .q_o     (swSync)
  );

  // An abort always beats a tick in the same cycle, so that tick is never counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ZERO: begin
        if (swSync) begin
          state_d = ST_WAIT1;
          cnt_d   = '0;
        end
      end
      ST_WAIT1: begin
        if (!swSync) begin
          state_d = ST_ZERO;
          cnt_d   = '0;
        end else if (m_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_ONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_ONE: begin
        if (!swSync) begin
          state_d = ST_WAIT0;
          cnt_d   = '0;
        end
      end
      ST_WAIT0: begin
        if (swSync) begin
          state_d = ST_ONE;
          cnt_d   = '0;
        end else if (m_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_ZERO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with the state register.
  always_comb begin
    level_d = levelOf(state_d);
    busy_d  = busyOf(state_d);
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ZERO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign db_level = level_q;
  assign db_rise  = rise_q;
  assign db_fall  = fall_q;
  assign busy     = busy_q;

endmodule
